// File: rtl/mul4_seq.sv
// mul4_seq: 4x4 unsigned sequential multiplier using shift-add over four cycles.
// All additions go through a single FA4 ripple adder instance.
// Optional build macro MUL4_SEQ_ZERO_SKIP_EN: if either operand is zero when a
// request is accepted, the block skips the iterations and goes straight to DONE
// with P = 0.

// FA4: 4-bit ripple-carry adder.
module FA4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       CIn,
  output logic [3:0] S,
  output logic       COut
);

  logic [4:0] carry;

  // Ripple the carry through the four bit positions.
  always_comb begin
    carry    = '0;
    carry[0] = CIn;
    S        = '0;
    for (int i = 0; i < 4; i++) begin
      S[i]       = A[i] ^ B[i] ^ carry[i];
      carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end
  end

  assign COut = carry[4];

endmodule

// state | meaning
// IDLE  | waiting for Start
// RUN   | one shift-add iteration per clock, four in total
// DONE  | product in P, Done high for this cycle; Start here chains the next op
module mul4_seq (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] P
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] m_q, m_d;
  logic [3:0] q_q, q_d;
  logic [3:0] h_q, h_d;
  logic       c_q, c_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] p_q, p_d;

  logic [3:0] fa_sum;
  logic       fa_cout;
  logic [4:0] acc;

  FA4 u_fa4 (
    .A    (h_q),
    .B    (m_q),
    .CIn  (1'b0),
    .S    (fa_sum),
    .COut (fa_cout)
  );

  // Register update; reset clears everything, including any operation in flight.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      q_q     <= '0;
      h_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      h_q     <= h_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  // Next-state logic: accept requests, iterate shift-add, and load the product on the last iteration.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    h_d     = h_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    acc     = q_q[0] ? {fa_cout, fa_sum} : {1'b0, h_q};

    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          m_d     = A;
          q_d     = B;
          h_d     = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
`ifdef MUL4_SEQ_ZERO_SKIP_EN
          if ((A == 4'd0) || (B == 4'd0)) begin
            p_d     = 8'h00;
            state_d = S_DONE;
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // {C,H} gets the add result, then {C,H,Q} shifts right; C refills with 0
        {c_d, h_d, q_d} = {1'b0, acc, q_q[3:1]};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          p_d     = {h_d, q_d};
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Busy = (state_q == S_RUN);
  assign Done = (state_q == S_DONE);
  assign P    = p_q;

endmodule
